// File: rtl/instr_fetch_mem_pkg.sv
// Shared constants for the instruction fetch memory.
// Holds parameter defaults plus the derived widths (WORD_BITS, IDX_W) and
// helper functions so overridden parameters derive the same way.
package instr_fetch_mem_pkg;

    localparam int DEF_DEPTH_BYTES = 512;
    localparam int DEF_WORD_BYTES  = 4;
    localparam int DEF_ADDR_W      = 32;

    // Width of one fetched instruction for a given bytes-per-word.
    function automatic int word_bits(input int wb);
        return 8 * wb;
    endfunction

    // Byte index width for a given store depth.
    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction

    localparam int WORD_BITS = word_bits(DEF_WORD_BYTES);
    localparam int IDX_W     = idx_w(DEF_DEPTH_BYTES);

endpackage

// File: rtl/instr_fetch_mem_resp_reg.sv
// fetch_resp_reg: registered fetch response with valid/ready flow control.
// Ports:
//   clk, reset         - clock, async active-high reset
//   req_valid          - upstream request present
//   req_ready          - request accepted this cycle if req_valid is high
//   ld_en              - program load in progress (blocks acceptance)
//   in_instr, in_fault - response data computed for the current request
//   resp_valid/ready   - downstream handshake
//   resp_instr/fault   - held response
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the response is held unchanged while resp_valid && !resp_ready.
module fetch_resp_reg #(
    parameter int WORD_BITS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 ld_en,
    input  logic [WORD_BITS-1:0] in_instr,
    input  logic                 in_fault,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [WORD_BITS-1:0] resp_instr,
    output logic                 resp_fault
);

    logic accept;

    // Reset is included so ready drops the instant reset asserts.
    assign req_ready = (!resp_valid || resp_ready) && !ld_en && !reset;
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_instr <= '0;
            resp_fault <= 1'b0;
        end else if (accept) begin
            resp_valid <= 1'b1;
            resp_instr <= in_instr;
            resp_fault <= in_fault;
        end else if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch_mem.sv
// instr_fetch_mem: byte-addressed instruction store with a one-cycle fetch port.
// Ports:
//   clk, reset                 - clock, async active-high reset
//   req_valid/req_ready/req_pc - fetch request (byte address)
//   resp_valid/resp_ready      - response handshake
//   resp_instr, resp_fault     - big-endian word, or fault with zero word
//   ld_en, ld_addr, ld_data    - program-load byte write (wins over fetch)
// Memory is not reset; it starts at zero and persists across reset.
module instr_fetch_mem
    import instr_fetch_mem_pkg::*;
#(
    parameter int DEPTH_BYTES = DEF_DEPTH_BYTES,
    parameter int WORD_BYTES  = DEF_WORD_BYTES,
    parameter int ADDR_W      = DEF_ADDR_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [ADDR_W-1:0]              req_pc,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [word_bits(WORD_BYTES)-1:0] resp_instr,
    output logic                           resp_fault,
    input  logic                           ld_en,
    input  logic [idx_w(DEPTH_BYTES)-1:0]  ld_addr,
    input  logic [7:0]                     ld_data
);

    localparam int WB = word_bits(WORD_BYTES);
    localparam int IW = idx_w(DEPTH_BYTES);

    logic [7:0]    mem [DEPTH_BYTES] = '{default: 8'h00};
    logic          misaligned;
    logic          out_of_range;
    logic          fault;
    logic [IW-1:0] base;
    logic [WB-1:0] rd_word;

    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // Range check uses the full pc so high bits cannot alias into the store.
    assign misaligned   = (req_pc & ADDR_W'(WORD_BYTES - 1)) != '0;
    assign out_of_range = req_pc > ADDR_W'(DEPTH_BYTES - WORD_BYTES);
    assign fault        = misaligned || out_of_range;
    assign base         = req_pc[IW-1:0];

    // Only indexed when in range, so base+k never wraps. mem[pc] lands in MSBs.
    always_comb begin
        rd_word = '0;
        if (!fault) begin
            for (int k = 0; k < WORD_BYTES; k++) begin
                rd_word[WB-1-8*k -: 8] = mem[base + IW'(k)];
            end
        end
    end

    fetch_resp_reg #(
        .WORD_BITS (WB)
    ) u_resp (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .ld_en      (ld_en),
        .in_instr   (rd_word),
        .in_fault   (fault),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_instr (resp_instr),
        .resp_fault (resp_fault)
    );

endmodule

// File: tb/tb_instr_fetch_mem.sv
module tb_instr_fetch_mem;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_instr;
    logic        resp_fault;
    logic        ld_en;
    logic [8:0]  ld_addr;
    logic [7:0]  ld_data;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [31:0] exp_q[$];

    instr_fetch_mem dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_pc     (req_pc),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_instr (resp_instr),
        .resp_fault (resp_fault),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_byte(input logic [8:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic load_word(input logic [8:0] a, input logic [31:0] w);
        load_byte(a,        w[31:24]);
        load_byte(a + 9'd1, w[23:16]);
        load_byte(a + 9'd2, w[15:8]);
        load_byte(a + 9'd3, w[7:0]);
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b1; req_pc = '0; resp_ready = 1'b1;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        #2;
        total_cnt++; if (resp_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", resp_valid); else pass_cnt++;
        total_cnt++; if (resp_instr !== 32'h0) $display("FAIL rst_instr: got %h want 0", resp_instr); else pass_cnt++;
        total_cnt++; if (resp_fault !== 1'b0) $display("FAIL rst_fault: got %b want 0", resp_fault); else pass_cnt++;
        total_cnt++; if (req_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", req_ready); else pass_cnt++;
        tick();
        total_cnt++; if (resp_valid !== 1'b0) $display("FAIL rst_hold_valid: got %b want 0", resp_valid); else pass_cnt++;
        req_valid = 1'b0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_load_fetch();
        load_word(9'd0, 32'h00430820);
        req_valid = 1'b1; req_pc = 32'd0; resp_ready = 1'b1;
        #1;
        total_cnt++; if (req_ready !== 1'b1) $display("FAIL lf_ready: got %b want 1", req_ready); else pass_cnt++;
        tick();
        req_valid = 1'b0;
        total_cnt++; if (resp_valid !== 1'b1) $display("FAIL lf_valid: got %b want 1", resp_valid); else pass_cnt++;
        total_cnt++; if (resp_instr !== 32'h00430820) $display("FAIL lf_instr: got %h want 00430820", resp_instr); else pass_cnt++;
        total_cnt++; if (resp_fault !== 1'b0) $display("FAIL lf_fault: got %b want 0", resp_fault); else pass_cnt++;
        tick();
        total_cnt++; if (resp_valid !== 1'b0) $display("FAIL lf_clear: got %b want 0", resp_valid); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        load_word(9'd4, 32'h11223344);
        load_word(9'd8, 32'ha1b2c3d4);
        exp_q.push_back(32'h00430820);
        exp_q.push_back(32'h11223344);
        exp_q.push_back(32'ha1b2c3d4);
        resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] exp_w;
            req_valid = 1'b1; req_pc = 32'(i * 4);
            #1;
            total_cnt++; if (req_ready !== 1'b1) $display("FAIL b2b_ready%0d: got %b want 1", i, req_ready); else pass_cnt++;
            tick();
            exp_w = exp_q.pop_front();
            total_cnt++; if (resp_valid !== 1'b1) $display("FAIL b2b_valid%0d: got %b want 1", i, resp_valid); else pass_cnt++;
            total_cnt++; if (resp_instr !== exp_w) $display("FAIL b2b_instr%0d: got %h want %h", i, resp_instr, exp_w); else pass_cnt++;
        end
        req_valid = 1'b0;
        tick();
        total_cnt++; if (resp_valid !== 1'b0) $display("FAIL b2b_clear: got %b want 0", resp_valid); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        req_valid = 1'b1; req_pc = 32'd4; resp_ready = 1'b0;
        tick();
        req_pc = 32'd8;
        for (int i = 0; i < 3; i++) begin
            #1;
            total_cnt++; if (req_ready !== 1'b0) $display("FAIL bp_ready%0d: got %b want 0", i, req_ready); else pass_cnt++;
            total_cnt++; if (resp_valid !== 1'b1) $display("FAIL bp_valid%0d: got %b want 1", i, resp_valid); else pass_cnt++;
            total_cnt++; if (resp_instr !== 32'h11223344) $display("FAIL bp_instr%0d: got %h want 11223344", i, resp_instr); else pass_cnt++;
            tick();
        end
        resp_ready = 1'b1;
        #1;
        total_cnt++; if (req_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", req_ready); else pass_cnt++;
        tick();
        req_valid = 1'b0;
        total_cnt++; if (resp_valid !== 1'b1) $display("FAIL bp_next_valid: got %b want 1", resp_valid); else pass_cnt++;
        total_cnt++; if (resp_instr !== 32'ha1b2c3d4) $display("FAIL bp_next_instr: got %h want a1b2c3d4", resp_instr); else pass_cnt++;
        tick();
    endtask

    task automatic test_faults();
        logic [31:0] pcs [5];
        logic        exp_f [5];
        logic [31:0] exp_i [5];
        load_word(9'd508, 32'hdeadbeef);
        pcs[0] = 32'd2;          exp_f[0] = 1'b1; exp_i[0] = 32'h0;
        pcs[1] = 32'd508;        exp_f[1] = 1'b0; exp_i[1] = 32'hdeadbeef;
        pcs[2] = 32'h0000_0200;  exp_f[2] = 1'b1; exp_i[2] = 32'h0;
        pcs[3] = 32'h8000_0000;  exp_f[3] = 1'b1; exp_i[3] = 32'h0;
        pcs[4] = 32'd509;        exp_f[4] = 1'b1; exp_i[4] = 32'h0;
        resp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_pc = pcs[i];
            tick();
            total_cnt++; if (resp_valid !== 1'b1) $display("FAIL flt_valid%0d: got %b want 1", i, resp_valid); else pass_cnt++;
            total_cnt++; if (resp_fault !== exp_f[i]) $display("FAIL flt_fault%0d: got %b want %b", i, resp_fault, exp_f[i]); else pass_cnt++;
            total_cnt++; if (resp_instr !== exp_i[i]) $display("FAIL flt_instr%0d: got %h want %h", i, resp_instr, exp_i[i]); else pass_cnt++;
        end
        req_valid = 1'b0;
        tick();
        total_cnt++; if (resp_valid !== 1'b0) $display("FAIL flt_clear: got %b want 0", resp_valid); else pass_cnt++;
    endtask

    task automatic test_load_priority();
        // Load wins over a simultaneous fetch.
        resp_ready = 1'b1;
        req_valid = 1'b1; req_pc = 32'd12;
        ld_en = 1'b1; ld_addr = 9'd13; ld_data = 8'h5a;
        #1;
        total_cnt++; if (req_ready !== 1'b0) $display("FAIL ldp_ready: got %b want 0", req_ready); else pass_cnt++;
        tick();
        ld_en = 1'b0;
        total_cnt++; if (resp_valid !== 1'b0) $display("FAIL ldp_noaccept: got %b want 0", resp_valid); else pass_cnt++;
        #1;
        total_cnt++; if (req_ready !== 1'b1) $display("FAIL ldp_ready_after: got %b want 1", req_ready); else pass_cnt++;
        tick();
        req_valid = 1'b0;
        total_cnt++; if (resp_valid !== 1'b1) $display("FAIL ldp_valid: got %b want 1", resp_valid); else pass_cnt++;
        total_cnt++; if (resp_instr !== 32'h005a0000) $display("FAIL ldp_instr: got %h want 005a0000", resp_instr); else pass_cnt++;
        // A held response survives a load that overlaps it.
        resp_ready = 1'b0;
        ld_en = 1'b1; ld_addr = 9'd12; ld_data = 8'h77;
        tick();
        ld_en = 1'b0;
        total_cnt++; if (resp_valid !== 1'b1) $display("FAIL ldp_hold_valid: got %b want 1", resp_valid); else pass_cnt++;
        total_cnt++; if (resp_instr !== 32'h005a0000) $display("FAIL ldp_hold_instr: got %h want 005a0000", resp_instr); else pass_cnt++;
        resp_ready = 1'b1;
        tick();
        total_cnt++; if (resp_valid !== 1'b0) $display("FAIL ldp_clear: got %b want 0", resp_valid); else pass_cnt++;
    endtask

    task automatic test_reset_midflight();
        req_valid = 1'b1; req_pc = 32'd4; resp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        total_cnt++; if (resp_valid !== 1'b1) $display("FAIL rmf_pre_valid: got %b want 1", resp_valid); else pass_cnt++;
        #2;
        reset = 1'b1;
        #1;
        total_cnt++; if (resp_valid !== 1'b0) $display("FAIL rmf_valid: got %b want 0", resp_valid); else pass_cnt++;
        total_cnt++; if (resp_instr !== 32'h0) $display("FAIL rmf_instr: got %h want 0", resp_instr); else pass_cnt++;
        total_cnt++; if (resp_fault !== 1'b0) $display("FAIL rmf_fault: got %b want 0", resp_fault); else pass_cnt++;
        total_cnt++; if (req_ready !== 1'b0) $display("FAIL rmf_ready: got %b want 0", req_ready); else pass_cnt++;
        tick();
        tick();
        reset = 1'b0;
        resp_ready = 1'b1;
        tick();
        total_cnt++; if (resp_valid !== 1'b0) $display("FAIL rmf_no_resp: got %b want 0", resp_valid); else pass_cnt++;
        req_valid = 1'b1; req_pc = 32'd0;
        tick();
        req_valid = 1'b0;
        total_cnt++; if (resp_valid !== 1'b1) $display("FAIL rmf_post_valid: got %b want 1", resp_valid); else pass_cnt++;
        total_cnt++; if (resp_instr !== 32'h00430820) $display("FAIL rmf_post_instr: got %h want 00430820", resp_instr); else pass_cnt++;
        tick();
    endtask

    initial begin
        test_reset();
        test_load_fetch();
        test_back_to_back();
        test_backpressure();
        test_faults();
        test_load_priority();
        test_reset_midflight();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
